// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks every N_IN-bit vector into a combinational gate in
// ascending order, samples the gate at the end of each hold window, and scores it.
module truth_table_sweeper #(
    parameter int unsigned N_IN = 3,
    parameter int unsigned HOLD = 5,
    parameter logic [(2**N_IN)-1:0] EXPECTED = 8'b1000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic [N_IN-1:0]          vec_out,
    input  logic                     dut_y,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [(2**N_IN)-1:0]     table_out,
    output logic [N_IN:0]            mismatch_cnt,
    output logic [N_IN-1:0]          first_fail,
    output logic                     fail_valid
);

    localparam int unsigned NV = 2**N_IN;
    localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int unsigned CW = N_IN + 1;
    localparam logic [N_IN-1:0] LAST_VEC  = N_IN'(NV - 1);
    localparam logic [HW-1:0]   LAST_HOLD = HW'(HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [N_IN-1:0]   r_vec, w_vec_nxt;
    logic [HW-1:0]     r_hold, w_hold_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_pass, w_pass_nxt;
    logic [NV-1:0]     r_table, w_table_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic [N_IN-1:0]   r_ff, w_ff_nxt;
    logic              r_fv, w_fv_nxt;

    logic              w_miss;
    logic              w_sample;
    logic [CW-1:0]     w_cnt_sampled;

    // Sample point is the last cycle of the hold window; earlier glitches never reach the score.
    assign w_sample      = (r_state == S_DRIVE) && (r_hold == LAST_HOLD);
    assign w_miss        = (dut_y != EXPECTED[r_vec]);
    assign w_cnt_sampled = w_miss ? (r_cnt + CW'(1)) : r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_vec   <= '0;
            r_hold  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_table <= '0;
            r_cnt   <= '0;
            r_ff    <= '0;
            r_fv    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
            r_hold  <= w_hold_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
            r_table <= w_table_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ff    <= w_ff_nxt;
            r_fv    <= w_fv_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_hold_nxt  = r_hold;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_pass_nxt  = r_pass;
        w_table_nxt = r_table;
        w_cnt_nxt   = r_cnt;
        w_ff_nxt    = r_ff;
        w_fv_nxt    = r_fv;

        case (r_state)
            S_IDLE, S_DONE: begin
                // A new sweep wipes every result of the previous one.
                if (start) begin
                    w_state_nxt = S_DRIVE;
                    w_vec_nxt   = '0;
                    w_hold_nxt  = '0;
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = 1'b0;
                    w_pass_nxt  = 1'b0;
                    w_table_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_ff_nxt    = '0;
                    w_fv_nxt    = 1'b0;
                end
            end
            S_DRIVE: begin
                if (w_sample) begin
                    w_table_nxt[r_vec] = dut_y;
                    w_cnt_nxt          = w_cnt_sampled;
                    if (w_miss && !r_fv) begin
                        w_ff_nxt = r_vec;
                        w_fv_nxt = 1'b1;
                    end
                    if (r_vec == LAST_VEC) begin
                        w_state_nxt = S_DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_pass_nxt  = (w_cnt_sampled == '0);
                    end else begin
                        w_vec_nxt  = r_vec + N_IN'(1);
                        w_hold_nxt = '0;
                    end
                end else begin
                    w_hold_nxt = r_hold + HW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign vec_out      = r_vec;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign table_out    = r_table;
    assign mismatch_cnt = r_cnt;
    assign first_fail   = r_ff;
    assign fail_valid   = r_fv;

endmodule
